// File: rtl/subleq_ctrl.sv
// rtl/subleq_ctrl.sv - SUBLEQ instruction sequencer
// Fetches a,b,c, loads mem[a]/mem[b], writes mem[b]-mem[a] and hands branch info to the PC stage.
module subleq_ctrl #(
  parameter int WIDTH = 64,
  parameter logic [WIDTH-1:0] HALT_ADDR = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [WIDTH-1:0] pc,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [3:0]       state,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] result,
  output logic             pc_ld,
  output logic             halted
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH_A   = 4'd1,
    FETCH_B   = 4'd2,
    FETCH_C   = 4'd3,
    LOAD_MA   = 4'd4,
    LOAD_MB   = 4'd5,
    EXEC      = 4'd6,
    WRITE_B   = 4'd7,
    UPDATE_PC = 4'd12,
    HALT      = 4'd15
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  state_t           cur;
  state_t           nxt;
  logic [WIDTH-1:0] ma;
  logic [WIDTH-1:0] mb;
  logic [WIDTH-1:0] diff;

  assign state = cur;
  assign diff  = mb - ma;

  always_ff @(posedge clk) begin
    if (!rst) cur <= IDLE;
    else      cur <= nxt;
  end

  // Memory states hold until acked; everything else is a fixed single-cycle step.
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:      nxt = run ? FETCH_A : IDLE;
      FETCH_A:   if (mem_ack) nxt = FETCH_B;
      FETCH_B:   if (mem_ack) nxt = FETCH_C;
      FETCH_C:   if (mem_ack) nxt = LOAD_MA;
      LOAD_MA:   if (mem_ack) nxt = LOAD_MB;
      LOAD_MB:   if (mem_ack) nxt = EXEC;
      EXEC:      nxt = WRITE_B;
      WRITE_B:   if (mem_ack) nxt = UPDATE_PC;
      UPDATE_PC: begin
        if (pc_ld && (c == HALT_ADDR)) nxt = HALT;
        else if (run)                  nxt = FETCH_A;
        else                           nxt = IDLE;
      end
      HALT:      nxt = HALT;
      default:   nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    halted    = (cur == HALT);
    case (cur)
      FETCH_A: begin mem_req = 1'b1; mem_addr = pc;       end
      FETCH_B: begin mem_req = 1'b1; mem_addr = pc + ONE; end
      FETCH_C: begin mem_req = 1'b1; mem_addr = pc + TWO; end
      LOAD_MA: begin mem_req = 1'b1; mem_addr = a;        end
      LOAD_MB: begin mem_req = 1'b1; mem_addr = b;        end
      WRITE_B: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = b;
        mem_wdata = result;
      end
      default: ;
    endcase
  end

  // Acks outside a memory state fall through the default and are ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a      <= '0;
      b      <= '0;
      c      <= '0;
      ma     <= '0;
      mb     <= '0;
      result <= '0;
      pc_ld  <= 1'b0;
    end else begin
      if (mem_ack) begin
        case (cur)
          FETCH_A: a  <= mem_rdata;
          FETCH_B: b  <= mem_rdata;
          FETCH_C: c  <= mem_rdata;
          LOAD_MA: ma <= mem_rdata;
          LOAD_MB: mb <= mem_rdata;
          default: ;
        endcase
      end
      if (cur == EXEC) begin
        result <= diff;
        pc_ld  <= diff[WIDTH-1] | (diff == '0);
      end
    end
  end

endmodule

// File: tb/tb_subleq_ctrl.sv
// tb/tb_subleq_ctrl.sv - bench for subleq_ctrl
// Task-driven memory responder with a scoreboard of expected write-backs and branch outcomes.
module tb_subleq_ctrl;
  localparam int W = 64;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic         clk = 1'b0;
  logic         rst, run;
  logic [W-1:0] pc;
  logic         mem_req, mem_we, mem_ack;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]   state;
  logic [W-1:0] a, b, c, result;
  logic         pc_ld, halted;

  subleq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .run(run), .pc(pc),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .state(state), .a(a), .b(b), .c(c), .result(result), .pc_ld(pc_ld), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] addr;
    logic [W-1:0] data;
    logic         pc_ld;
    logic [W-1:0] c;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         e;
  logic [W-1:0] wr_addr_q[$];
  logic [W-1:0] wr_data_q[$];
  logic [W-1:0] mem[16];
  int           wait_cfg[16];
  int           waited;
  int           errors = 0;
  int           checks = 0;

  int           ncyc, nupd;
  int           n_in_state[16];
  logic [W-1:0] first_addr[16];
  bit           unstable;
  logic         upd_pc_ld;
  logic [W-1:0] upd_c, upd_result;

  // Advance to the next falling edge, then answer whatever request the DUT presents.
  task automatic tick();
    @(negedge clk);
    mem_ack = 1'b0;
    if (mem_req) begin
      if (waited >= wait_cfg[state]) begin
        mem_ack = 1'b1;
        waited  = 0;
        if (mem_we) begin
          mem[mem_addr[3:0]] = mem_wdata;
          wr_addr_q.push_back(mem_addr);
          wr_data_q.push_back(mem_wdata);
        end else begin
          mem_rdata = mem[mem_addr[3:0]];
        end
      end else begin
        waited++;
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      wait_cfg[i] = 0;
    end
    waited = 0;
  endtask

  task automatic exec_instr();
    bit done = 0;
    state_prev_init: begin end
    ncyc = 0; nupd = 0; unstable = 0;
    for (int i = 0; i < 16; i++) begin n_in_state[i] = 0; first_addr[i] = '0; end
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int g = 0; g < 200; g++) begin
      if (state == 4'd0 || state == 4'd15) begin done = 1; break; end
      ncyc++;
      n_in_state[state]++;
      if (n_in_state[state] == 1) first_addr[state] = mem_addr;
      else if (mem_addr !== first_addr[state]) unstable = 1;
      if (state == 4'd12) begin
        nupd++;
        upd_pc_ld = pc_ld; upd_c = c; upd_result = result;
      end
      tick();
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL exec_timeout: instruction did not finish, state=%0d", state);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; run = 1'b0; pc = '0; mem_ack = 1'b0; mem_rdata = '0;
    clear_mem();
    tick(); tick();
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if ({a, b, c, result} !== '0) begin errors++; $display("FAIL reset_regs: a=%0h b=%0h c=%0h r=%0h want 0", a, b, c, result); end
    checks++; if ({pc_ld, halted, mem_req, mem_we} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {pc_ld, halted, mem_req, mem_we}); end
    checks++; if ({mem_addr, mem_wdata} !== '0) begin errors++; $display("FAIL reset_bus: addr=%0h wdata=%0h want 0", mem_addr, mem_wdata); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    clear_mem(); pc = '0;
    mem[0] = 3; mem[1] = 4; mem[2] = 9; mem[3] = 5; mem[4] = 7;
    exp_q.push_back('{addr: 4, data: 2, pc_ld: 1'b0, c: 9});
    exec_instr();
    checks++; if (ncyc !== 8) begin errors++; $display("FAIL basic_cycles: got %0d want 8", ncyc); end
    checks++; if (nupd !== 1) begin errors++; $display("FAIL basic_update_count: got %0d want 1", nupd); end
    checks++; if (upd_result !== 64'd2) begin errors++; $display("FAIL basic_result: got %0h want 2", upd_result); end
    checks++; if (first_addr[4] !== 64'd3 || first_addr[5] !== 64'd4) begin errors++; $display("FAIL basic_load_addr: ma=%0h mb=%0h want 3 4", first_addr[4], first_addr[5]); end
    e = exp_q.pop_front();
    checks++;
    if (wr_addr_q.size() != 1) begin errors++; $display("FAIL basic_write_count: got %0d want 1", wr_addr_q.size()); wr_addr_q.delete(); wr_data_q.delete(); end
    else if (wr_addr_q[0] !== e.addr || wr_data_q[0] !== e.data) begin errors++; $display("FAIL basic_write: got %0h@%0h want %0h@%0h", wr_data_q[0], wr_addr_q[0], e.data, e.addr); end
    wr_addr_q.delete(); wr_data_q.delete();
    checks++; if (upd_pc_ld !== e.pc_ld || upd_c !== e.c) begin errors++; $display("FAIL basic_branch: pc_ld=%b c=%0h want %b %0h", upd_pc_ld, upd_c, e.pc_ld, e.c); end
  endtask

  task automatic test_zero_result();
    clear_mem(); pc = '0;
    mem[0] = 3; mem[1] = 4; mem[2] = 9; mem[3] = 7; mem[4] = 7;
    exp_q.push_back('{addr: 4, data: 0, pc_ld: 1'b1, c: 9});
    exec_instr();
    e = exp_q.pop_front();
    checks++; if (upd_result !== 64'd0) begin errors++; $display("FAIL zero_result: got %0h want 0", upd_result); end
    checks++; if (upd_pc_ld !== e.pc_ld || upd_c !== e.c) begin errors++; $display("FAIL zero_branch: pc_ld=%b c=%0h want %b %0h", upd_pc_ld, upd_c, e.pc_ld, e.c); end
    checks++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== e.addr || wr_data_q[0] !== e.data) begin errors++; $display("FAIL zero_write: count=%0d want 1 write of %0h@%0h", wr_addr_q.size(), e.data, e.addr); end
    wr_addr_q.delete(); wr_data_q.delete();
  endtask

  task automatic test_wrap_result();
    clear_mem(); pc = '0;
    mem[0] = 3; mem[1] = 4; mem[2] = 9; mem[3] = 1; mem[4] = 64'h8000_0000_0000_0000;
    exp_q.push_back('{addr: 4, data: 64'h7FFF_FFFF_FFFF_FFFF, pc_ld: 1'b0, c: 9});
    exec_instr();
    e = exp_q.pop_front();
    checks++; if (upd_result !== e.data) begin errors++; $display("FAIL wrap_result: got %0h want %0h", upd_result, e.data); end
    checks++; if (upd_pc_ld !== e.pc_ld) begin errors++; $display("FAIL wrap_pc_ld: got %b want %b", upd_pc_ld, e.pc_ld); end
    wr_addr_q.delete(); wr_data_q.delete();
  endtask

  task automatic test_pc_wrap_same_operand();
    clear_mem(); pc = 64'hFFFF_FFFF_FFFF_FFFE;
    mem[14] = 5; mem[15] = 5; mem[0] = 9; mem[5] = 42;
    exp_q.push_back('{addr: 5, data: 0, pc_ld: 1'b1, c: 9});
    exec_instr();
    e = exp_q.pop_front();
    checks++; if (first_addr[2] !== ONES || first_addr[3] !== 64'd0) begin errors++; $display("FAIL pc_wrap_addr: b_addr=%0h c_addr=%0h want %0h 0", first_addr[2], first_addr[3], ONES); end
    checks++; if (upd_pc_ld !== e.pc_ld || upd_c !== e.c) begin errors++; $display("FAIL same_operand_branch: pc_ld=%b c=%0h want %b %0h", upd_pc_ld, upd_c, e.pc_ld, e.c); end
    checks++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== e.addr || wr_data_q[0] !== e.data) begin errors++; $display("FAIL same_operand_write: count=%0d want 0@5", wr_addr_q.size()); end
    wr_addr_q.delete(); wr_data_q.delete();
  endtask

  task automatic test_halt();
    int bad_halted = 0, bad_req = 0;
    clear_mem(); pc = '0;
    mem[0] = 3; mem[1] = 4; mem[2] = ONES; mem[3] = 7; mem[4] = 7;
    exec_instr();
    checks++; if (nupd !== 1 || state !== 4'd15) begin errors++; $display("FAIL halt_entry: updates=%0d state=%0d want 1 15", nupd, state); end
    for (int i = 0; i < 20; i++) begin
      if (halted !== 1'b1 || state !== 4'd15) bad_halted++;
      if (mem_req !== 1'b0) bad_req++;
      tick();
    end
    checks++; if (bad_halted != 0) begin errors++; $display("FAIL halt_sticky: %0d bad cycles want 0", bad_halted); end
    checks++; if (bad_req != 0) begin errors++; $display("FAIL halt_no_req: %0d request cycles want 0", bad_req); end
    rst = 1'b0; run = 1'b1;
    tick();
    checks++; if (state !== 4'd0 || halted !== 1'b0) begin errors++; $display("FAIL halt_reset: state=%0d halted=%b want 0 0", state, halted); end
    rst = 1'b1; run = 1'b0;
    tick();
    wr_addr_q.delete(); wr_data_q.delete();
  endtask

  task automatic test_wait_states();
    clear_mem(); pc = '0;
    mem[0] = 3; mem[1] = 4; mem[2] = 9; mem[3] = 5; mem[4] = 7;
    wait_cfg[5] = 3;
    exec_instr();
    checks++; if (ncyc !== 11) begin errors++; $display("FAIL wait_cycles: got %0d want 11", ncyc); end
    checks++; if (n_in_state[5] !== 4 || first_addr[5] !== 64'd4 || unstable) begin errors++; $display("FAIL wait_hold: cycles=%0d addr=%0h unstable=%0d want 4 4 0", n_in_state[5], first_addr[5], unstable); end
    wr_addr_q.delete(); wr_data_q.delete();
  endtask

  task automatic test_back_to_back();
    bit done = 0;
    logic [W-1:0] fetch2_addr = '1;
    clear_mem(); pc = '0;
    mem[0] = 6; mem[1] = 7; mem[2] = 3; mem[3] = 6; mem[4] = 7; mem[5] = 9; mem[6] = 10; mem[7] = 4;
    exp_q.push_back('{addr: 7, data: -64'sd6,  pc_ld: 1'b1, c: 3});
    exp_q.push_back('{addr: 7, data: -64'sd16, pc_ld: 1'b1, c: 9});
    ncyc = 0; nupd = 0;
    run = 1'b1;
    tick();
    for (int g = 0; g < 100; g++) begin
      if (state == 4'd0) begin done = 1; break; end
      ncyc++;
      if (state == 4'd1 && nupd == 1 && ncyc == 9) fetch2_addr = mem_addr;
      if (state == 4'd12) begin
        if (nupd == 0) pc = 64'd3;
        else run = 1'b0;
        nupd++;
      end
      tick();
    end
    checks++; if (!done || ncyc !== 16 || nupd !== 2) begin errors++; $display("FAIL b2b_cycles: done=%0d cycles=%0d updates=%0d want 1 16 2", done, ncyc, nupd); end
    checks++; if (fetch2_addr !== 64'd3) begin errors++; $display("FAIL b2b_fetch_pc: got %0h want 3", fetch2_addr); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (wr_addr_q.size() == 0) begin errors++; $display("FAIL b2b_write_missing: want %0h@%0h", e.data, e.addr); end
      else begin
        if (wr_addr_q[0] !== e.addr || wr_data_q[0] !== e.data) begin errors++; $display("FAIL b2b_write: got %0h@%0h want %0h@%0h", wr_data_q[0], wr_addr_q[0], e.data, e.addr); end
        void'(wr_addr_q.pop_front()); void'(wr_data_q.pop_front());
      end
    end
    checks++; if (upd_dummy_ok(pc_ld, c) !== 1'b1) begin errors++; $display("FAIL b2b_last_branch: pc_ld=%b c=%0h want 1 9", pc_ld, c); end
    wr_addr_q.delete(); wr_data_q.delete();
  endtask

  function automatic logic upd_dummy_ok(input logic l, input logic [W-1:0] cc);
    return (l === 1'b1) && (cc === 64'd9);
  endfunction

  task automatic test_reset_mid_write();
    bit reached = 0;
    clear_mem(); pc = '0;
    mem[0] = 3; mem[1] = 4; mem[2] = 9; mem[3] = 5; mem[4] = 7;
    wait_cfg[7] = 5;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int g = 0; g < 50; g++) begin
      if (state == 4'd7) begin reached = 1; break; end
      tick();
    end
    checks++; if (!reached) begin errors++; $display("FAIL rst_write_reach: state=%0d want 7", state); end
    rst = 1'b0;
    tick();
    waited = 0;
    checks++; if (state !== 4'd0 || mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rst_write_state: state=%0d req=%b we=%b want 0 0 0", state, mem_req, mem_we); end
    checks++; if ({a, b, c, result, mem_addr, mem_wdata} !== '0 || pc_ld !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL rst_write_outputs: a=%0h b=%0h c=%0h r=%0h pc_ld=%b want all 0", a, b, c, result, pc_ld); end
    checks++; if (wr_addr_q.size() != 0 || mem[4] !== 64'd7) begin errors++; $display("FAIL rst_write_dropped: writes=%0d mem4=%0h want 0 7", wr_addr_q.size(), mem[4]); end
    rst = 1'b1; wait_cfg[7] = 0; pc = 64'd5; run = 1'b1;
    tick();
    run = 1'b0;
    checks++; if (state !== 4'd1 || mem_addr !== 64'd5 || mem_req !== 1'b1) begin errors++; $display("FAIL rst_restart: state=%0d addr=%0h req=%b want 1 5 1", state, mem_addr, mem_req); end
    for (int g = 0; g < 40; g++) begin
      if (state == 4'd0 || state == 4'd15) break;
      tick();
    end
    wr_addr_q.delete(); wr_data_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_result();
    test_wrap_result();
    test_pc_wrap_same_operand();
    test_wait_states();
    test_back_to_back();
    test_halt();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/subleq_ctrl.md
# subleq_ctrl

Instruction sequencer for the SUBLEQ CPU. It fetches the three-word instruction `a, b, c` at `pc`, `pc+1`, `pc+2`, then loads `mem[a]` and `mem[b]`. It computes `mem[b] - mem[a]`, writes the result back to `mem[b]`, and drives `state`, `c` and `pc_ld` into the PC-increment stage during `UPDATE_PC`. It sits directly upstream of the PC-increment stage, and the external PC register captures `next_pc` every cycle.

## Interface
- `WIDTH`, default 64: data and address width.
- `HALT_ADDR`, default `{WIDTH{1'b1}}`: a branch target equal to this value halts the CPU.
- `clk` input 1: the only clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-low reset.
- `run` input 1: start/continue enable.
- `pc` input WIDTH: current PC value from the PC register.
- `mem_req` output 1: memory request, held until `mem_ack`.
- `mem_we` output 1: 1 = write, 0 = read; valid while `mem_req` = 1.
- `mem_addr` output WIDTH: request address.
- `mem_wdata` output WIDTH: write data.
- `mem_ack` input 1: completes the current request; for reads, `mem_rdata` is valid in the same cycle.
- `mem_rdata` input WIDTH: read data.
- `state` output 4: current state code, consumed by the PC stage.
- `a`, `b`, `c` outputs WIDTH: the fetched instruction words.
- `result` output WIDTH: `mem[b] - mem[a]`.
- `pc_ld` output 1: 1 when `result` ≤ 0 (signed), i.e. the branch to `c` is taken.
- `halted` output 1: 1 while in `HALT`.

## Operation
- State codes:
  - `IDLE` = 0
  - `FETCH_A` = 1
  - `FETCH_B` = 2
  - `FETCH_C` = 3
  - `LOAD_MA` = 4
  - `LOAD_MB` = 5
  - `EXEC` = 6
  - `WRITE_B` = 7
  - `UPDATE_PC` = 12
  - `HALT` = 15
  - Unused codes go to `IDLE`.
- Transitions:
  - `IDLE` → `FETCH_A` when `run` = 1.
  - Each memory state advances only in a cycle with `mem_ack` = 1; otherwise it holds with request outputs unchanged.
  - Sequence: `FETCH_A` → `FETCH_B` → `FETCH_C` → `LOAD_MA` → `LOAD_MB` → `EXEC` → `WRITE_B` → `UPDATE_PC`.
  - `EXEC` lasts exactly one cycle.
  - `UPDATE_PC` → `HALT` if `pc_ld` = 1 and `c` == `HALT_ADDR`; else → `FETCH_A` if `run` = 1; else → `IDLE`.
  - `HALT` is sticky until reset.
- Memory outputs are decoded combinationally from the state and registered operands:
  - `FETCH_A`: `mem_addr` = `pc`, read.
  - `FETCH_B`: `mem_addr` = `pc+1`, read.
  - `FETCH_C`: `mem_addr` = `pc+2`, read.
  - `LOAD_MA`: `mem_addr` = `a`, read.
  - `LOAD_MB`: `mem_addr` = `b`, read.
  - `WRITE_B`: `mem_addr` = `b`, `mem_we` = 1, `mem_wdata` = `result`.
  - All other states: `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0.
- Registers capture `mem_rdata` on the ack edge: `a` in `FETCH_A`, `b` in `FETCH_B`, `c` in `FETCH_C`, and internal `ma`/`mb` in `LOAD_MA`/`LOAD_MB`.
- `EXEC` edge:
  - `result` ← `mb - ma`, modulo 2^WIDTH (wrap-around, no overflow flag).
  - `pc_ld` ← `result[WIDTH-1]` | (`result` == 0), computed from the wrapped value.
- `pc_ld`, `c` and `result` hold from the `EXEC` edge until the next `EXEC` edge or reset.
- `a` == `b` is legal: the result is 0, `pc_ld` = 1, and 0 is written to `mem[b]`.
- Address arithmetic `pc+1` and `pc+2` wraps modulo 2^WIDTH.
- `run` dropping mid-instruction has no effect until `UPDATE_PC`; the instruction always completes.
- `mem_ack` outside a request is ignored.

## Timing
- Reset (`rst` = 0 at an edge) clears everything; the next cycle shows:
  - `state` = `IDLE`
  - `a` = `b` = `c` = `result` = 0
  - `pc_ld` = 0, `halted` = 0
  - `mem_req` = `mem_we` = 0, `mem_addr` = `mem_wdata` = 0
- Reset overrides every state, including mid-request and `HALT`. An abandoned request is dropped with no completion.
- Zero-wait memory (`mem_ack` in the first request cycle): 8 cycles per instruction, `FETCH_A` through `UPDATE_PC`.
- Each wait cycle on any memory op adds exactly 1 cycle.
- `UPDATE_PC` lasts exactly 1 cycle.
- The PC register loads `next_pc` at the end of `UPDATE_PC`, so the following `FETCH_A` drives the updated `pc`.
- From `IDLE` with `run` = 1, `FETCH_A` begins the cycle after.

## Test plan
- Reset, then `run` = 1, `pc` = 0, memory = {0:3, 1:4, 2:9, 3:5, 4:7}, zero-wait → `mem[4]` = 2, `pc_ld` = 0 in `UPDATE_PC` at cycle 8, `state` 12 seen once.
- Same program but `mem[3]` = 7 → `result` = 0, `pc_ld` = 1, `c` = 9 in `UPDATE_PC`, `mem[4]` written 0.
- `mem[3]` = 1, `mem[4]` = `64'h8000_0000_0000_0000` → `result` = `64'h7FFF_FFFF_FFFF_FFFF` (wrap), `pc_ld` = 0.
- `c` = all-ones with a taken branch → `UPDATE_PC` then `HALT`, `halted` = 1 held 20 cycles, `mem_req` = 0; `rst` = 0 → `IDLE`.
- Insert 3 wait cycles on `LOAD_MB` → `state` holds at 5 with stable `mem_addr` = `b`, and the instruction takes 11 cycles.
- Assert `rst` = 0 during `WRITE_B` → next cycle `state` = 0, `mem_req` = 0, all outputs at reset values; `run` = 1 restarts at `FETCH_A` with `mem_addr` = `pc`.
